pe_result_collector: RTL and testbench

- Parametrised successor to the fixed two-PE-per-memory result hookup in the accelerator top.
- Accepts result tiles from NUM_PE PEs. The PEs issue valid-only pulses and cannot be stalled.
- Buffers each PE's tiles in a private FIFO and merges them round-robin onto one valid/ready write port toward an output CIM memory.
- Adds what the previous hookup lacked: backpressure tolerance, overflow detection, and a flush/drain handshake that the main controller uses before asserting conv_completed.

---
 rtl/pe_result_collector_if.sv | 52 +++++
 rtl/pe_result_collector.sv | 230 +++++++++++++++++++++++
 tb/tb_pe_result_collector.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_result_collector_if.sv
// ---------------------------------------------------------------------------
// pe_result_collector_if
// Bundles the PE result bus and the output memory write port of the result
// collector.
//   pe_tile_i   : NUM_PE flattened tiles, PE k at [k*TILE_W +: TILE_W]
//   pe_addr_i   : NUM_PE result addresses, PE k at [k*ADDR_W +: ADDR_W]
//   pe_valid_i  : one-cycle result strobe per PE (PEs cannot be stalled)
//   mem_ready_i : memory side accepts the current output entry
//   mem_tile_o  : tile being written
//   mem_addr_o  : address of mem_tile_o
//   mem_src_o   : index of the PE that produced mem_tile_o
//   mem_valid_o : output holds a valid entry
// Modports: master = PE array / memory environment, slave = the collector.
// ---------------------------------------------------------------------------
interface pe_result_collector_if #(
    parameter int NUM_PE = 4,
    parameter int TILE_W = 432,
    parameter int ADDR_W = 8
);
    localparam int SRC_W = $clog2(NUM_PE);

    logic [NUM_PE*TILE_W-1:0] pe_tile_i;
    logic [NUM_PE*ADDR_W-1:0] pe_addr_i;
    logic [NUM_PE-1:0]        pe_valid_i;
    logic                     mem_ready_i;
    logic [TILE_W-1:0]        mem_tile_o;
    logic [ADDR_W-1:0]        mem_addr_o;
    logic [SRC_W-1:0]         mem_src_o;
    logic                     mem_valid_o;

    modport master (
        output pe_tile_i,
        output pe_addr_i,
        output pe_valid_i,
        output mem_ready_i,
        input  mem_tile_o,
        input  mem_addr_o,
        input  mem_src_o,
        input  mem_valid_o
    );

    modport slave (
        input  pe_tile_i,
        input  pe_addr_i,
        input  pe_valid_i,
        input  mem_ready_i,
        output mem_tile_o,
        output mem_addr_o,
        output mem_src_o,
        output mem_valid_o
    );
endinterface

// File: rtl/pe_result_collector.sv
// ---------------------------------------------------------------------------
// pe_result_collector
// Collects result tiles from NUM_PE non-stallable PEs, buffers each PE in a
// private FIFO and merges them round-robin onto a single valid/ready write
// port toward the output CIM memory. Tracks per-PE overflow and provides a
// flush/drain handshake for the main controller.
// Ports:
//   clk          : single clock
//   reset        : asynchronous, active-high
//   bus          : PE result bus + memory write port (slave modport)
//   flush_i      : one-cycle request to drain all buffered results
//   clear_ovf_i  : clears the sticky overflow bits
//   fifo_full_o  : per-PE FIFO full (registered)
//   overflow_o   : sticky per-PE "a push was dropped"
//   idle_o       : all FIFOs empty and no valid output entry
//   flush_done_o : one-cycle pulse when a drain completes
// ---------------------------------------------------------------------------
module pe_result_collector #(
    parameter int NUM_PE     = 4,
    parameter int DATA_W     = 12,
    parameter int TILE_DIM   = 6,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    pe_result_collector_if.slave  bus,
    input  logic                  flush_i,
    input  logic                  clear_ovf_i,
    output logic [NUM_PE-1:0]     fifo_full_o,
    output logic [NUM_PE-1:0]     overflow_o,
    output logic                  idle_o,
    output logic                  flush_done_o
);
    localparam int TILE_W  = TILE_DIM * TILE_DIM * DATA_W;
    localparam int ENTRY_W = TILE_W + ADDR_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SRC_W   = $clog2(NUM_PE);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [SRC_W:0]   NUM_PE_C = (SRC_W + 1)'(NUM_PE);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // (base + off) mod NUM_PE; both operands are below NUM_PE so a single
    // conditional subtract is enough, also for non-power-of-two NUM_PE.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input logic [SRC_W-1:0] off);
        logic [SRC_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= NUM_PE_C) begin
            sum = sum - NUM_PE_C;
        end else begin
            sum = sum;
        end
        return sum[SRC_W-1:0];
    endfunction

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] fifo_mem_q [NUM_PE][FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_PE];
    logic [PTR_W-1:0]   wr_ptr_d [NUM_PE];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_PE];
    logic [PTR_W-1:0]   rd_ptr_d [NUM_PE];
    logic [CNT_W-1:0]   cnt_q    [NUM_PE];
    logic [CNT_W-1:0]   cnt_d    [NUM_PE];
    logic [NUM_PE-1:0]  full_q, full_d;
    logic [NUM_PE-1:0]  ovf_q, ovf_d;
    logic [NUM_PE-1:0]  nonempty_s, push_s, drop_s, pop_s;

    // Arbiter and output register
    logic               load_en_s, found_s, hit_s;
    logic [SRC_W-1:0]   scan_idx_s, sel_s;
    logic [SRC_W-1:0]   rr_q, rr_d;
    logic               valid_q, valid_d;
    logic [TILE_W-1:0]  tile_q, tile_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [ENTRY_W-1:0] head_s;

    // Drain FSM
    state_t             state_q;
    logic               flush_done_q;
    logic               idle_s, no_push_s;

    // Round-robin scan from rr over the FIFO contents registered before the edge
    always_comb begin
        found_s    = 1'b0;
        sel_s      = '0;
        hit_s      = 1'b0;
        scan_idx_s = '0;
        for (int k = 0; k < NUM_PE; k++) begin
            nonempty_s[k] = (cnt_q[k] != '0);
        end
        for (int i = 0; i < NUM_PE; i++) begin
            scan_idx_s = wrap_add(rr_q, i[SRC_W-1:0]);
            hit_s      = !found_s && nonempty_s[scan_idx_s];
            sel_s      = hit_s ? scan_idx_s : sel_s;
            found_s    = found_s | nonempty_s[scan_idx_s];
        end
        load_en_s = !valid_q || bus.mem_ready_i;
        head_s    = fifo_mem_q[sel_s][rd_ptr_q[sel_s]];
    end

    // Per-PE push/pop decisions and next FIFO bookkeeping
    always_comb begin
        for (int k = 0; k < NUM_PE; k++) begin
            pop_s[k]    = load_en_s && found_s && (sel_s == k[SRC_W-1:0]);
            // A full FIFO still accepts when it is popped on the same edge.
            push_s[k]   = bus.pe_valid_i[k] && (!full_q[k] || pop_s[k]);
            drop_s[k]   = bus.pe_valid_i[k] && !push_s[k];
            cnt_d[k]    = cnt_q[k] + CNT_W'(push_s[k]) - CNT_W'(pop_s[k]);
            wr_ptr_d[k] = wr_ptr_q[k] + PTR_W'(push_s[k]);
            rd_ptr_d[k] = rd_ptr_q[k] + PTR_W'(pop_s[k]);
            full_d[k]   = (cnt_d[k] == DEPTH_C);
        end
        // A drop in the same cycle as a clear leaves the bit set.
        ovf_d = drop_s | (ovf_q & ~{NUM_PE{clear_ovf_i}});
    end

    // Output register next state: load the arbiter winner or go empty
    always_comb begin
        valid_d = valid_q;
        tile_d  = tile_q;
        addr_d  = addr_q;
        src_d   = src_q;
        rr_d    = rr_q;
        if (load_en_s) begin
            if (found_s) begin
                valid_d = 1'b1;
                tile_d  = head_s[ENTRY_W-1:ADDR_W];
                addr_d  = head_s[ADDR_W-1:0];
                src_d   = sel_s;
                rr_d    = wrap_add(sel_s, SRC_W'(1'b1));
            end else begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // FIFO payload storage; emptiness is tracked by the pointers, so no reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PE; k++) begin
            if (push_s[k]) begin
                fifo_mem_q[k][wr_ptr_q[k]] <= {bus.pe_tile_i[k*TILE_W +: TILE_W],
                                               bus.pe_addr_i[k*ADDR_W +: ADDR_W]};
            end
        end
    end

    // Control state: pointers, occupancy, flags, arbiter pointer, output entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_PE; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
            full_q  <= '0;
            ovf_q   <= '0;
            rr_q    <= '0;
            valid_q <= 1'b0;
            tile_q  <= '0;
            addr_q  <= '0;
            src_q   <= '0;
        end else begin
            for (int k = 0; k < NUM_PE; k++) begin
                wr_ptr_q[k] <= wr_ptr_d[k];
                rd_ptr_q[k] <= rd_ptr_d[k];
                cnt_q[k]    <= cnt_d[k];
            end
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            tile_q  <= tile_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
        end
    end

    assign idle_s    = !(|nonempty_s) && !valid_q;
    assign no_push_s = !(|bus.pe_valid_i);

    // Drain FSM; a flush that arrives while already idle completes at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_RUN;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (flush_i) begin
                        if (idle_s && no_push_s) begin
                            flush_done_q <= 1'b1;
                        end else begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (idle_s && no_push_s) begin
                        state_q      <= ST_RUN;
                        flush_done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign bus.mem_tile_o  = tile_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_src_o   = src_q;
    assign bus.mem_valid_o = valid_q;
    assign fifo_full_o     = full_q;
    assign overflow_o      = ovf_q;
    assign idle_o          = idle_s;
    assign flush_done_o    = flush_done_q;

endmodule

// File: tb/tb_pe_result_collector.sv
// ---------------------------------------------------------------------------
// tb_pe_result_collector
// Self-checking bench for pe_result_collector (NUM_PE=4, FIFO_DEPTH=4).
// Expected output entries are queued when stimulus is driven and compared
// at every output handshake; flags and timing are checked against constants.
// ---------------------------------------------------------------------------
module tb_pe_result_collector;
    localparam int NUM_PE     = 4;
    localparam int DATA_W     = 12;
    localparam int TILE_DIM   = 6;
    localparam int ADDR_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int TILE_W     = TILE_DIM * TILE_DIM * DATA_W;
    localparam int SRC_W      = 2;

    typedef struct packed {
        logic [SRC_W-1:0]  src;
        logic [ADDR_W-1:0] addr;
        logic [TILE_W-1:0] tile;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush_s;
    logic              clear_ovf_s;
    logic [NUM_PE-1:0] fifo_full_s;
    logic [NUM_PE-1:0] ovf_s;
    logic              idle_s;
    logic              flush_done_s;

    exp_t sb_q[$];
    int   checks_r  = 0;
    int   errors_r  = 0;
    int   cyc_r     = 0;
    int   last_hs_r = 0;

    pe_result_collector_if #(.NUM_PE(NUM_PE), .TILE_W(TILE_W), .ADDR_W(ADDR_W)) bus ();

    pe_result_collector #(
        .NUM_PE(NUM_PE), .DATA_W(DATA_W), .TILE_DIM(TILE_DIM),
        .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .flush_i      (flush_s),
        .clear_ovf_i  (clear_ovf_s),
        .fifo_full_o  (fifo_full_s),
        .overflow_o   (ovf_s),
        .idle_o       (idle_s),
        .flush_done_o (flush_done_s)
    );

    // Free-running clock, 10 time units
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks_r++;
        if (obs !== exp) begin
            errors_r++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TILE_W-1:0] rand_tile();
        logic [447:0] t;
        for (int i = 0; i < 14; i++) t[i*32 +: 32] = $urandom();
        return t[TILE_W-1:0];
    endfunction

    // Raise PE k's strobe for the next edge; queue the entry if it should come out
    task automatic drive_pe(input int k, input logic [ADDR_W-1:0] addr, input bit expect_out);
        logic [TILE_W-1:0] tile;
        exp_t e;
        tile = rand_tile();
        bus.pe_valid_i[k] = 1'b1;
        bus.pe_addr_i[k*ADDR_W +: ADDR_W] = addr;
        bus.pe_tile_i[k*TILE_W +: TILE_W] = tile;
        if (expect_out) begin
            e.src  = k[SRC_W-1:0];
            e.addr = addr;
            e.tile = tile;
            sb_q.push_back(e);
        end
    endtask

    // One clock: note a handshake before the edge, score it after, clear strobes
    task automatic tick();
        bit   hs;
        exp_t got;
        exp_t e;
        hs       = bus.mem_valid_o && bus.mem_ready_i;
        got.src  = bus.mem_src_o;
        got.addr = bus.mem_addr_o;
        got.tile = bus.mem_tile_o;
        @(posedge clk);
        #1;
        cyc_r++;
        if (hs) begin
            last_hs_r = cyc_r;
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", {488'd0, got.addr, 16'd0}, 512'd0);
            end else begin
                e = sb_q.pop_front();
                check("out_src", got.src, e.src);
                check("out_addr", got.addr, e.addr);
                check("out_tile", got.tile, e.tile);
            end
        end
        bus.pe_valid_i = '0;
        flush_s        = 1'b0;
        clear_ovf_s    = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, bus.mem_valid_o, 1'b0);
        check({tag, "_tile"}, bus.mem_tile_o, 512'd0);
        check({tag, "_addr"}, bus.mem_addr_o, 8'h00);
        check({tag, "_src"}, bus.mem_src_o, 2'd0);
        check({tag, "_ovf"}, ovf_s, 4'b0000);
        check({tag, "_full"}, fifo_full_s, 4'b0000);
        check({tag, "_done"}, flush_done_s, 1'b0);
        check({tag, "_idle"}, idle_s, 1'b1);
    endtask

    initial begin
        int pulses;
        int pulse_cyc;
        bus.pe_valid_i  = '0;
        bus.pe_addr_i   = '0;
        bus.pe_tile_i   = '0;
        bus.mem_ready_i = 1'b0;
        flush_s         = 1'b0;
        clear_ovf_s     = 1'b0;
        reset           = 1'b1;
        #12;
        reset = 1'b0;
        check_reset_values("rst");

        // Single result from PE2; no bypass, visible after the second edge
        bus.mem_ready_i = 1'b1;
        drive_pe(2, 8'h1A, 1'b1);
        tick();
        check("single_no_bypass", bus.mem_valid_o, 1'b0);
        tick();
        check("single_valid", bus.mem_valid_o, 1'b1);
        check("single_addr", bus.mem_addr_o, 8'h1A);
        check("single_src", bus.mem_src_o, 2'd2);
        tick();
        check("single_valid_drop", bus.mem_valid_o, 1'b0);
        check("single_idle", idle_s, 1'b1);

        // Fairness: rr back to 0 via PE3, then bursts 0,1,2,3 twice
        drive_pe(3, 8'h33, 1'b1);
        run(3);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < NUM_PE; k++) drive_pe(k, k[ADDR_W-1:0], 1'b1);
            run(6);
        end
        // rr preset to 2 via PE1, burst comes out 2,3,0,1
        drive_pe(1, 8'h11, 1'b1);
        run(3);
        drive_pe(2, 8'h02, 1'b1);
        drive_pe(3, 8'h03, 1'b1);
        drive_pe(0, 8'h00, 1'b1);
        drive_pe(1, 8'h01, 1'b1);
        run(6);
        check("fair_sb_left", sb_q.size(), 0);
        check("fair_idle", idle_s, 1'b1);

        // Backpressure: PE0 every cycle for 10 cycles, only 5 make it in
        bus.mem_ready_i = 1'b0;
        for (int p = 0; p < 10; p++) begin
            drive_pe(0, 8'h40 + p[ADDR_W-1:0], p < 5);
            tick();
            if (p >= 1) check("bp_hold_addr", bus.mem_addr_o, 8'h40);
        end
        check("bp_valid", bus.mem_valid_o, 1'b1);
        check("bp_full", fifo_full_s, 4'b0001);
        check("bp_ovf", ovf_s, 4'b0001);
        // Clear coinciding with a drop keeps the bit; clear alone drops it
        drive_pe(0, 8'hEE, 1'b0);
        clear_ovf_s = 1'b1;
        tick();
        check("ovf_clear_vs_drop", ovf_s, 4'b0001);
        clear_ovf_s = 1'b1;
        tick();
        check("ovf_clear", ovf_s, 4'b0000);
        bus.mem_ready_i = 1'b1;
        run(6);
        check("bp_sb_left", sb_q.size(), 0);
        check("bp_full_after", fifo_full_s, 4'b0000);
        check("bp_idle", idle_s, 1'b1);

        // Flush with 3 queued tiles (rr=1 -> order 1,2,3), ready toggling,
        // repeated flush requests during the drain
        bus.mem_ready_i = 1'b0;
        drive_pe(1, 8'h51, 1'b1);
        drive_pe(2, 8'h52, 1'b1);
        drive_pe(3, 8'h53, 1'b1);
        tick();
        pulses    = 0;
        pulse_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            bus.mem_ready_i = (i % 2 == 0);
            if (i == 0 || i == 2 || i == 4) flush_s = 1'b1;
            tick();
            if (flush_done_s) begin
                pulses++;
                pulse_cyc = cyc_r;
            end
        end
        check("flush_pulses", pulses, 1);
        check("flush_pulse_time", pulse_cyc, last_hs_r + 1);
        check("flush_sb_left", sb_q.size(), 0);
        // Flush while idle completes on the next cycle
        bus.mem_ready_i = 1'b1;
        flush_s = 1'b1;
        tick();
        check("flush_idle_done", flush_done_s, 1'b1);
        tick();
        check("flush_idle_single", flush_done_s, 1'b0);

        // Reset between edges with entries in flight
        bus.mem_ready_i = 1'b0;
        drive_pe(2, 8'h62, 1'b0);
        drive_pe(3, 8'h63, 1'b0);
        tick();
        drive_pe(1, 8'h64, 1'b0);
        drive_pe(3, 8'h65, 1'b0);
        tick();
        check("pre_reset_valid", bus.mem_valid_o, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async_rst");
        #1;
        reset = 1'b0;
        bus.mem_ready_i = 1'b1;
        drive_pe(1, 8'h71, 1'b1);
        drive_pe(3, 8'h73, 1'b1);
        run(4);
        check("post_reset_sb_left", sb_q.size(), 0);
        check("post_reset_idle", idle_s, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end
endmodule
